uart_program_loader: RTL

UART_PROGRAM_LOADER -- requirements
Module: uart_program_loader

---
 rtl/rs232_pkg.sv | 24 ++
 rtl/uart_byte_poller.sv | 46 ++++
 rtl/uart_program_loader.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// Shared RS232 core register map and loader state encodings.
// Used by the UART program loader and its byte poller.
package rs232_pkg;

  localparam logic [4:0] RX_BASE     = 5'h00;
  localparam logic [4:0] TX_BASE     = 5'h04;
  localparam logic [4:0] STATUS_BASE = 5'h08;
  localparam int         TX_OK_BIT   = 6;
  localparam int         RX_OK_BIT   = 7;

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_CSUM,
    S_START,
    S_RUN
  } ld_state_e;

  typedef enum logic {
    S_POLL,
    S_READ
  } byte_phase_e;

endpackage

// File: rtl/uart_byte_poller.sv
// Fetches one RX byte per request: poll STATUS until RX_OK, then read RX.
// Address and read only change on completed (non-stalled) accesses.
module uart_byte_poller
  import rs232_pkg::*;
(
  input  logic        avm_clk,
  input  logic        avm_rst,
  input  logic        req,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic [7:0]  rx_byte,
  output logic        rx_valid
);

  byte_phase_e phase_q, phase_d;
  logic        acc_done;
  logic        unused_rd;

  assign avm_read    = req;
  assign avm_address = (phase_q == S_READ) ? RX_BASE : STATUS_BASE;
  assign acc_done    = req && !avm_waitrequest;
  assign rx_byte     = avm_readdata[7:0];
  assign rx_valid    = acc_done && (phase_q == S_READ);
  assign unused_rd   = ^avm_readdata[31:8];

  // next phase: advance only when an access completes
  always_comb begin
    phase_d = phase_q;
    if (acc_done) begin
      unique case (phase_q)
        S_POLL: if (avm_readdata[RX_OK_BIT]) phase_d = S_READ;
        S_READ: phase_d = S_POLL;
        default: phase_d = S_POLL;
      endcase
    end
  end

  // phase register
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) phase_q <= S_POLL;
    else         phase_q <= phase_d;
  end

endmodule

// File: rtl/uart_program_loader.sv
// Loads a length-prefixed program from the RS232 core into IMEM, then starts the CPU.
// Optional trailing XOR checksum byte enabled by LOADER_CHECKSUM_EN.
module uart_program_loader
  import rs232_pkg::*;
#(
  parameter int IMEM_ADDR_W = 10,
  parameter int MAX_WORDS   = 2**IMEM_ADDR_W
) (
  input  logic                   avm_clk,
  input  logic                   avm_rst,
  output logic [4:0]             avm_address,
  output logic                   avm_read,
  input  logic [31:0]            avm_readdata,
  output logic                   avm_write,
  output logic [31:0]            avm_writedata,
  input  logic                   avm_waitrequest,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_wdata,
  output logic                   o_cpu_start,
  input  logic                   i_cpu_done,
  output logic                   o_busy,
  output logic                   o_error
);

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  ld_state_e   state_q, state_d;
  logic        req;
  logic        bvalid;
  logic [7:0]  bdata;
  logic        hdr_q;
  logic [15:0] n_q;
  logic [15:0] widx_q;
  logic [1:0]  bidx_q;
  logic [23:0] asm_q;
  logic [15:0] n_hdr;
  logic        hdr_bad;
  logic        last_byte;
  logic        last_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
  logic        csum_ok;
  assign csum_ok = (bdata == csum_q);
`endif

  assign avm_write     = 1'b0;
  assign avm_writedata = 32'd0;
  assign req           = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign n_hdr         = {bdata, n_q[7:0]};
  assign hdr_bad       = (n_hdr == 16'd0) || ({1'b0, n_hdr} > MAXW);
  assign last_byte     = (bidx_q == 2'd3);
  assign last_word     = ((widx_q + 16'd1) == n_q);

  uart_byte_poller u_poll (
    .avm_clk         (avm_clk),
    .avm_rst         (avm_rst),
    .req             (req),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .rx_byte         (bdata),
    .rx_valid        (bvalid)
  );

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HDR:   if (bvalid && hdr_q && !hdr_bad) state_d = S_DATA;
      S_DATA:  if (bvalid && last_byte && last_word)
`ifdef LOADER_CHECKSUM_EN
                 state_d = S_CSUM;
`else
                 state_d = S_START;
`endif
`ifdef LOADER_CHECKSUM_EN
      S_CSUM:  if (bvalid) state_d = csum_ok ? S_START : S_HDR;
`endif
      S_START: state_d = S_RUN;
      S_RUN:   if (i_cpu_done && !o_cpu_start) state_d = S_HDR;
      default: state_d = S_HDR;
    endcase
  end

  // state register
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) state_q <= S_HDR;
    else         state_q <= state_d;
  end

  // header capture, word assembly, IMEM writes and status flags
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      hdr_q        <= 1'b0;
      n_q          <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      asm_q        <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
      o_cpu_start  <= 1'b0;
      o_busy       <= 1'b0;
      o_error      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      o_imem_we   <= 1'b0;
      o_cpu_start <= (state_q == S_START);
      unique case (state_q)
        S_HDR: if (bvalid) begin
          if (!hdr_q) begin
            hdr_q      <= 1'b1;
            n_q[7:0]   <= bdata;
            o_busy     <= 1'b1;
            o_error    <= 1'b0;
          end else begin
            hdr_q      <= 1'b0;
            widx_q     <= '0;
            bidx_q     <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
            if (hdr_bad) begin
              o_error  <= 1'b1;
              o_busy   <= 1'b0;
            end else begin
              n_q      <= n_hdr;
            end
          end
        end
        S_DATA: if (bvalid) begin
          bidx_q <= bidx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum_q <= csum_q ^ bdata;
`endif
          unique case (bidx_q)
            2'd0: asm_q[7:0]   <= bdata;
            2'd1: asm_q[15:8]  <= bdata;
            2'd2: asm_q[23:16] <= bdata;
            default: begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= widx_q[IMEM_ADDR_W-1:0];
              o_imem_wdata <= {bdata, asm_q};
              widx_q       <= widx_q + 16'd1;
            end
          endcase
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: if (bvalid && !csum_ok) begin
          o_error <= 1'b1;
          o_busy  <= 1'b0;
        end
`endif
        S_RUN: if (i_cpu_done && !o_cpu_start) o_busy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
